// File: rtl/mem_arbiter.sv
// Memory arbiter: queues one fetch/load/store/IO request per kind and issues them,
// one at a time, to a shared byte engine with fixed priority plus fetch anti-starvation.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_size,
    input  logic        ld_signed,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [2:0]  st_size,
    input  logic [31:0] st_data,
    input  logic        io_req,
    output logic        if_done,
    output logic [31:0] if_data,
    output logic        ld_done,
    output logic [31:0] ld_data,
    output logic        st_done,
    output logic        io_done,
    output logic [31:0] io_data,
    output logic        mem_valid,
    output logic [1:0]  mem_kind,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_size,
    output logic        mem_signed,
    output logic [31:0] mem_wdata,
    input  logic        mem_done,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] K_IF = 2'd0;
    localparam logic [1:0] K_LD = 2'd1;
    localparam logic [1:0] K_ST = 2'd2;
    localparam logic [1:0] K_IO = 2'd3;
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DISCARD = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [1:0]     cur_q, cur_d;
    logic [3:0]     pend_q, pend_d;
    logic [31:0]    if_addr_q, if_addr_d, ld_addr_q, ld_addr_d;
    logic [31:0]    st_addr_q, st_addr_d, st_data_q, st_data_d;
    logic [2:0]     ld_size_q, ld_size_d, st_size_q, st_size_d;
    logic           ld_signed_q, ld_signed_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic           valid_q, valid_d, signed_q, signed_d;
    logic [1:0]     kind_q, kind_d;
    logic [31:0]    addr_q, addr_d, wdata_q, wdata_d;
    logic [2:0]     size_q, size_d;
    logic [3:0]     done_q, done_d;
    logic [31:0]    if_data_q, if_data_d, ld_data_q, ld_data_d, io_data_q, io_data_d;

    logic [3:0]     req_s, busy_s, acc_s, pend_eff_s, gnt_mask_s;
    logic           gnt_s, kill_s;
    logic [1:0]     gnt_kind_s;

    // Request acceptance and grant selection; flag vectors are indexed by kind code.
    always_comb begin
        req_s      = {io_req, st_req, ld_req, if_req};
        busy_s     = (state_q == S_BUSY) ? (4'b0001 << cur_q) : 4'b0000;
        acc_s      = req_s & ~pend_q & ~busy_s & (clear ? 4'b0100 : 4'b1111);
        pend_eff_s = (clear ? (pend_q & 4'b0100) : pend_q) | acc_s;
        gnt_s      = 1'b0;
        gnt_kind_s = K_IF;
        if (state_q == S_IDLE) begin
            gnt_s = |pend_eff_s;
            if (pend_eff_s[K_IO]) begin
                gnt_kind_s = K_IO;
            end else if (pend_eff_s[K_ST]) begin
                gnt_kind_s = K_ST;
            end else if (pend_eff_s[K_IF] && (starve_q >= LIMIT)) begin
                gnt_kind_s = K_IF;
            end else if (pend_eff_s[K_LD]) begin
                gnt_kind_s = K_LD;
            end else begin
                gnt_kind_s = K_IF;
            end
        end else begin
            gnt_s = 1'b0;
        end
        gnt_mask_s = gnt_s ? (4'b0001 << gnt_kind_s) : 4'b0000;
        kill_s     = clear && (cur_q != K_ST);
    end

    // Next-state, latched request fields, issue and completion outputs.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        pend_d      = pend_eff_s & ~gnt_mask_s;
        if_addr_d   = acc_s[K_IF] ? if_addr   : if_addr_q;
        ld_addr_d   = acc_s[K_LD] ? ld_addr   : ld_addr_q;
        ld_size_d   = acc_s[K_LD] ? ld_size   : ld_size_q;
        ld_signed_d = acc_s[K_LD] ? ld_signed : ld_signed_q;
        st_addr_d   = acc_s[K_ST] ? st_addr   : st_addr_q;
        st_size_d   = acc_s[K_ST] ? st_size   : st_size_q;
        st_data_d   = acc_s[K_ST] ? st_data   : st_data_q;
        valid_d     = 1'b0;
        kind_d      = kind_q;
        addr_d      = addr_q;
        size_d      = size_q;
        signed_d    = signed_q;
        wdata_d     = wdata_q;
        done_d      = 4'b0000;
        if_data_d   = if_data_q;
        ld_data_d   = ld_data_q;
        io_data_d   = io_data_q;

        if (clear) begin
            starve_d = '0;
        end else if (gnt_s && (gnt_kind_s == K_IF)) begin
            starve_d = '0;
        end else if (!pend_eff_s[K_IF]) begin
            starve_d = '0;
        end else if (gnt_s && (gnt_kind_s == K_LD) && (starve_q < LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end

        case (state_q)
            S_IDLE: begin
                if (gnt_s) begin
                    valid_d = 1'b1;
                    kind_d  = gnt_kind_s;
                    cur_d   = gnt_kind_s;
                    state_d = S_BUSY;
                    case (gnt_kind_s)
                        K_IF: begin
                            addr_d = if_addr_d; size_d = 3'd4; signed_d = 1'b0; wdata_d = 32'd0;
                        end
                        K_LD: begin
                            addr_d = ld_addr_d; size_d = ld_size_d; signed_d = ld_signed_d; wdata_d = 32'd0;
                        end
                        K_ST: begin
                            addr_d = st_addr_d; size_d = st_size_d; signed_d = 1'b0; wdata_d = st_data_d;
                        end
                        default: begin
                            addr_d = 32'd0; size_d = 3'd1; signed_d = 1'b0; wdata_d = 32'd0;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                // A flush coinciding with completion of a non-store simply drops the result.
                if (mem_done) begin
                    state_d = S_IDLE;
                    if (!kill_s) begin
                        done_d = 4'b0001 << cur_q;
                        case (cur_q)
                            K_IF:    if_data_d = mem_rdata;
                            K_LD:    ld_data_d = mem_rdata;
                            K_IO:    io_data_d = {24'd0, mem_rdata[7:0]};
                            default: if_data_d = if_data_q;
                        endcase
                    end else begin
                        done_d = 4'b0000;
                    end
                end else if (kill_s) begin
                    state_d = S_DISCARD;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DISCARD: state_d = mem_done ? S_IDLE : S_DISCARD;
            default:   state_d = S_IDLE;
        endcase
    end

    // State register; everything freezes while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;     cur_q <= 2'd0;        pend_q <= 4'd0;
            if_addr_q <= 32'd0;    ld_addr_q <= 32'd0;   st_addr_q <= 32'd0;
            st_data_q <= 32'd0;    ld_size_q <= 3'd0;    st_size_q <= 3'd0;
            ld_signed_q <= 1'b0;   starve_q <= '0;       valid_q <= 1'b0;
            kind_q <= 2'd0;        addr_q <= 32'd0;      size_q <= 3'd0;
            signed_q <= 1'b0;      wdata_q <= 32'd0;     done_q <= 4'd0;
            if_data_q <= 32'd0;    ld_data_q <= 32'd0;   io_data_q <= 32'd0;
        end else if (rdy) begin
            state_q <= state_d;    cur_q <= cur_d;       pend_q <= pend_d;
            if_addr_q <= if_addr_d; ld_addr_q <= ld_addr_d; st_addr_q <= st_addr_d;
            st_data_q <= st_data_d; ld_size_q <= ld_size_d; st_size_q <= st_size_d;
            ld_signed_q <= ld_signed_d; starve_q <= starve_d; valid_q <= valid_d;
            kind_q <= kind_d;      addr_q <= addr_d;     size_q <= size_d;
            signed_q <= signed_d;  wdata_q <= wdata_d;   done_q <= done_d;
            if_data_q <= if_data_d; ld_data_q <= ld_data_d; io_data_q <= io_data_d;
        end
    end

    // Pulses held over a stall are presented once rdy returns.
    assign mem_valid  = valid_q & rdy;
    assign if_done    = done_q[K_IF] & rdy;
    assign ld_done    = done_q[K_LD] & rdy;
    assign st_done    = done_q[K_ST] & rdy;
    assign io_done    = done_q[K_IO] & rdy;
    assign mem_kind   = kind_q;
    assign mem_addr   = addr_q;
    assign mem_size   = size_q;
    assign mem_signed = signed_q;
    assign mem_wdata  = wdata_q;
    assign if_data    = if_data_q;
    assign ld_data    = ld_data_q;
    assign io_data    = io_data_q;
endmodule
